// File: rtl/uart_transceiver.sv
// Full-duplex UART with parametrised framing, valid/ready byte handshakes and per-frame error flags.
// One instance per serial port, between the board pins and the command/LED logic.
module uart_transceiver #(
    parameter int unsigned CLK_HZ    = 27000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned IDX_W        = 4;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] READY_AT  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY != 0);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rxState_t;

    txState_t               txState, txStateNext;
    logic [CNT_W-1:0]       txCnt, txCntNext;
    logic [IDX_W-1:0]       txBits, txBitsNext;
    logic                   txStop, txStopNext;
    logic [DATA_BITS-1:0]   txShift, txShiftNext;
    logic                   txParBit, txParBitNext;
    logic                   uartTxNext, txReadyNext;

    rxState_t               rxState, rxStateNext;
    logic                   rxSync1, rxSync2;
    logic [CNT_W-1:0]       rxCnt, rxCntNext;
    logic [IDX_W-1:0]       rxBits, rxBitsNext;
    logic [DATA_BITS-1:0]   rxShift, rxShiftNext;
    logic                   rxParBit, rxParBitNext;
    logic [DATA_BITS-1:0]   rxDataNext;
    logic                   rxValidNext, rxParErrNext, rxFrameErrNext, rxOverrunNext;

    logic txHandshake, txBitDone, rxLine, rxSample;

    assign txHandshake = tx_valid && tx_ready;
    assign txBitDone   = (txCnt == BIT_LAST);
    assign rxLine      = rxSync2;
    assign rxSample    = (rxState == RX_START) ? (rxCnt == HALF_LAST) : (rxCnt == BIT_LAST);

    // State and datapath registers for both directions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txState       <= TX_IDLE;
            txCnt         <= '0;
            txBits        <= '0;
            txStop        <= 1'b0;
            txShift       <= '0;
            txParBit      <= 1'b0;
            uart_tx       <= 1'b1;
            tx_ready      <= 1'b1;
            rxState       <= RX_IDLE;
            rxSync1       <= 1'b1;
            rxSync2       <= 1'b1;
            rxCnt         <= '0;
            rxBits        <= '0;
            rxShift       <= '0;
            rxParBit      <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            txState       <= txStateNext;
            txCnt         <= txCntNext;
            txBits        <= txBitsNext;
            txStop        <= txStopNext;
            txShift       <= txShiftNext;
            txParBit      <= txParBitNext;
            uart_tx       <= uartTxNext;
            tx_ready      <= txReadyNext;
            rxState       <= rxStateNext;
            rxSync1       <= uart_rx;
            rxSync2       <= rxSync1;
            rxCnt         <= rxCntNext;
            rxBits        <= rxBitsNext;
            rxShift       <= rxShiftNext;
            rxParBit      <= rxParBitNext;
            rx_data       <= rxDataNext;
            rx_valid      <= rxValidNext;
            rx_parity_err <= rxParErrNext;
            rx_frame_err  <= rxFrameErrNext;
            rx_overrun    <= rxOverrunNext;
        end
    end

    // TX next state
    always_comb begin
        txStateNext = txState;
        case (txState)
            TX_IDLE:   if (txHandshake) txStateNext = TX_START;
            TX_START:  if (txBitDone) txStateNext = TX_DATA;
            TX_DATA:   if (txBitDone && txBits == DATA_LAST)
                           txStateNext = HAS_PAR ? TX_PARITY : TX_STOP;
            TX_PARITY: if (txBitDone) txStateNext = TX_STOP;
            TX_STOP:   if (txBitDone && txStop == STOP_LAST)
                           txStateNext = txHandshake ? TX_START : TX_IDLE;
            default:   txStateNext = TX_IDLE;
        endcase
    end

    // TX outputs: the line value for the upcoming bit is registered on each bit boundary
    always_comb begin
        txCntNext    = (txState == TX_IDLE || txBitDone) ? '0 : txCnt + CNT_W'(1);
        txBitsNext   = txBits;
        txStopNext   = txStop;
        txShiftNext  = txShift;
        txParBitNext = txParBit;
        uartTxNext   = uart_tx;
        txReadyNext  = tx_ready;
        case (txState)
            TX_IDLE: begin
                if (txHandshake) begin
                    txShiftNext  = tx_data;
                    txParBitNext = (^tx_data) ^ ODD_PAR;
                    txBitsNext   = '0;
                    uartTxNext   = 1'b0;
                    txReadyNext  = 1'b0;
                end
            end
            TX_START: begin
                if (txBitDone) begin
                    uartTxNext = txShift[0];
                    txBitsNext = '0;
                end
            end
            TX_DATA: begin
                if (txBitDone) begin
                    if (txBits == DATA_LAST) begin
                        uartTxNext = HAS_PAR ? txParBit : 1'b1;
                        txStopNext = 1'b0;
                    end else begin
                        txShiftNext = txShift >> 1;
                        uartTxNext  = txShift[1];
                        txBitsNext  = txBits + IDX_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (txBitDone) begin
                    uartTxNext = 1'b1;
                    txStopNext = 1'b0;
                end
            end
            TX_STOP: begin
                // Ready during the final stop cycle lets the next start bit follow with no gap
                if (txStop == STOP_LAST && txCnt == READY_AT) txReadyNext = 1'b1;
                if (txBitDone) begin
                    if (txStop != STOP_LAST) begin
                        txStopNext = txStop + 1'b1;
                    end else if (txHandshake) begin
                        txShiftNext  = tx_data;
                        txParBitNext = (^tx_data) ^ ODD_PAR;
                        txBitsNext   = '0;
                        uartTxNext   = 1'b0;
                        txReadyNext  = 1'b0;
                    end
                end
            end
            default: begin
                uartTxNext  = 1'b1;
                txReadyNext = 1'b1;
            end
        endcase
    end

    // RX next state
    always_comb begin
        rxStateNext = rxState;
        case (rxState)
            RX_IDLE:      if (!rxLine) rxStateNext = RX_START;
            RX_START:     if (rxSample) rxStateNext = rxLine ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rxSample && rxBits == DATA_LAST)
                              rxStateNext = HAS_PAR ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rxSample) rxStateNext = RX_STOP;
            RX_STOP:      if (rxSample) rxStateNext = rxLine ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rxLine) rxStateNext = RX_IDLE;
            default:      rxStateNext = RX_IDLE;
        endcase
    end

    // RX outputs: assemble LSB first, publish or drop on the stop sample
    always_comb begin
        rxCntNext      = (rxState == RX_IDLE || rxState == RX_WAIT_HIGH || rxSample)
                         ? '0 : rxCnt + CNT_W'(1);
        rxBitsNext     = rxBits;
        rxShiftNext    = rxShift;
        rxParBitNext   = rxParBit;
        rxDataNext     = rx_data;
        rxValidNext    = rx_valid;
        rxParErrNext   = rx_parity_err;
        rxFrameErrNext = rx_frame_err;
        rxOverrunNext  = 1'b0;
        if (rx_valid && rx_ready) rxValidNext = 1'b0;
        case (rxState)
            RX_START: if (rxSample) rxBitsNext = '0;
            RX_DATA: begin
                if (rxSample) begin
                    rxShiftNext = {rxLine, rxShift[DATA_BITS-1:1]};
                    rxBitsNext  = (rxBits == DATA_LAST) ? '0 : rxBits + IDX_W'(1);
                end
            end
            RX_PARITY: if (rxSample) rxParBitNext = rxLine;
            RX_STOP: begin
                if (rxSample) begin
                    if (!rx_valid || rx_ready) begin
                        rxDataNext     = rxShift;
                        rxParErrNext   = HAS_PAR && (rxParBit != ((^rxShift) ^ ODD_PAR));
                        rxFrameErrNext = !rxLine;
                        rxValidNext    = 1'b1;
                    end else begin
                        rxOverrunNext = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Parametrised full-duplex UART that succeeds the fixed 8N1/234-clock design.
- Data width, parity mode, stop-bit count and baud divisor are set by parameters.
- Adds valid/ready byte handshakes on both directions, false-start rejection, and per-frame parity, framing and overrun flags.
- Sits between the board UART pins and the command/LED logic; one instance per serial port.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz
BAUD, 115200, line rate; localparam CLKS_PER_BIT = CLK_HZ/BAUD (234 at defaults), must be >= 8
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits transmitted, legal 1 or 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
uart_rx  in  1  asynchronous serial input, idle high
uart_tx  out  1  serial output, idle high
tx_data  in  DATA_BITS  byte to send, sampled on tx handshake
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter can accept a byte
rx_data  out  DATA_BITS  last received payload
rx_valid  out  1  rx_data/flags valid, held until consumed
rx_ready  in  1  consumer accepts rx_data
rx_parity_err  out  1  parity mismatch on the frame in rx_data (0 when PARITY=0)
rx_frame_err  out  1  stop bit sampled low on the frame in rx_data
rx_overrun  out  1  one-cycle pulse: completed frame dropped because holding register was full

Behaviour:
- Reset (rst_n=0 at a clk edge) values: uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, both FSMs IDLE, bit counters 0, rx synchroniser flops =1.
- Reset mid-frame abandons the frame. uart_tx is high on the first edge with rst_n low. No partial rx output is produced.
- Bit-timer width is $clog2(CLKS_PER_BIT+1). Every transmitted bit lasts exactly CLKS_PER_BIT cycles.
- Parity bit: even = XOR of payload bits; odd = inverted XOR. The parity bit follows the MSB, and payload is sent LSB first.
- TX FSM states: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP.
  - Handshake is tx_valid && tx_ready. tx_data is latched, tx_ready falls on the next edge, and uart_tx goes low on that same edge (1-cycle latency).
  - Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - tx_ready rises during the last cycle of the final stop bit. A handshake in that cycle starts the next start bit on the following edge, so back-to-back frames have no idle gap.
  - tx_data changes while busy are ignored.
- RX front end: 2-flop synchroniser on uart_rx; FSM uses the synchronised value only.
- RX FSM states: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP, WAIT_HIGH.
  - IDLE -> START when the synchronised line is 0.
  - START samples the line after CLKS_PER_BIT/2 cycles. If the sample is 1, it is a false start: return to IDLE with no output and no flags.
  - Each following bit is sampled CLKS_PER_BIT cycles after the previous sample. Data is assembled LSB first.
  - STOP samples only the first stop bit, even when STOP_BITS=2.
    - Stop bit = 1: go to IDLE on the next edge (re-armed mid-stop-bit).
    - Stop bit = 0: go to WAIT_HIGH; stay there until the line reads 1, then go to IDLE. A break therefore yields exactly one frame.
- Frame completion (edge after stop sample):
  - Holding register empty, or rx_ready high in that cycle: load rx_data and flags, rx_valid=1.
  - Else: keep old data and flags, pulse rx_overrun for 1 cycle, drop the new frame.
- rx_valid clears on the edge after a cycle with rx_valid && rx_ready, unless a frame completes in that same cycle.
- rx_data and flags are stable while rx_valid=1.

Test Plan:
- Bench parameters: CLK_HZ=1600, BAUD=100 (CLKS_PER_BIT=16), DATA_BITS=8, PARITY=0, STOP_BITS=1, unless stated otherwise.
- TX 0x2B: pulse tx_valid -> uart_tx low 16 cycles, then bits 1,1,0,1,0,1,0,0 for 16 cycles each, then high. tx_ready is low for 159 cycles; a second byte queued keeps the next start bit immediately after the stop bit.
- Loopback, PARITY=1, send 0x2D -> parity bit 0, rx_data=0x2D, rx_valid=1, rx_parity_err=0. Repeat with the injected parity bit flipped -> rx_parity_err=1, rx_data=0x2D.
- Glitch: drive uart_rx low for 5 cycles, then high -> rx_valid never rises. A valid 0x55 sent afterwards is received correctly.
- Framing: send 0xA5 with the stop bit driven low and the line held low 40 more cycles -> one rx_valid with rx_frame_err=1. No second frame until the line returns high and a new start bit arrives.
- Overrun: rx_ready=0, receive 0x11 then 0x22 -> rx_data stays 0x11, and rx_overrun pulses exactly once at completion of 0x22. Raising rx_ready for 1 cycle clears rx_valid.
- Reset mid-TX: assert rst_n=0 during data bit 3 of 0xFF -> uart_tx=1 on that edge and tx_ready=1. After release, a new 0x00 frame transmits cleanly with STOP_BITS=2 (stop high for 32 cycles).
